// File: rtl/ycr1_mem_port_arbiter_pkg.sv
// Shared memory-interface encodings for the core memory port arbiter.
// Command, access width and response codes used on every port.
package ycr1_mem_port_arbiter_pkg;

    typedef enum logic {
        YCR1_MEM_CMD_RD = 1'b0,
        YCR1_MEM_CMD_WR = 1'b1
    } type_ycr1_mem_cmd_e;

    typedef enum logic [1:0] {
        YCR1_MEM_WIDTH_BYTE  = 2'b00,
        YCR1_MEM_WIDTH_HWORD = 2'b01,
        YCR1_MEM_WIDTH_WORD  = 2'b10
    } type_ycr1_mem_width_e;

    typedef enum logic [1:0] {
        YCR1_MEM_RESP_NOTRDY = 2'b00,
        YCR1_MEM_RESP_RDY_OK = 2'b01,
        YCR1_MEM_RESP_RDY_ER = 2'b10
    } type_ycr1_mem_resp_e;

    // The unused 2'b11 code is reported to masters as an error
    function automatic logic [1:0] ycr1_resp_norm(input logic [1:0] r);
        return (r == 2'b11) ? YCR1_MEM_RESP_RDY_ER : r;
    endfunction

endpackage

// File: rtl/ycr1_arb2_rr.sv
// Two-way grant selection: round-robin or fixed priority (M1 wins),
// with a grant lock that holds a stalled master until it is accepted.
module ycr1_arb2_rr #(
    parameter int unsigned YCR1_ARB_RR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    input  logic       stall,
    output logic       grant
);

    logic last_r;
    logic lock_r;
    logic lock_g_r;

    always_comb begin
        grant = ~last_r;
        if (lock_r) begin
            grant = lock_g_r;
        end else if (YCR1_ARB_RR != 0) begin
            if (req == 2'b11) begin
                grant = ~last_r;
            end else if (req[1]) begin
                grant = 1'b1;
            end else if (req[0]) begin
                grant = 1'b0;
            end
        end else begin
            grant = req[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r   <= 1'b1;
            lock_r   <= 1'b0;
            lock_g_r <= 1'b0;
        end else if (accept) begin
            last_r <= grant;
            lock_r <= 1'b0;
        end else if (stall) begin
            lock_r   <= 1'b1;
            lock_g_r <= grant;
        end
    end

endmodule

// File: rtl/ycr1_mem_port_arbiter.sv
// Shares one memory port between instruction fetch (M0) and data (M1),
// one outstanding transaction, back-to-back issue on RDY_OK.
module ycr1_mem_port_arbiter
    import ycr1_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned YCR1_AWIDTH = 32,
    parameter int unsigned YCR1_DWIDTH = 32,
    parameter int unsigned YCR1_ARB_RR = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_req,
    input  logic                   m0_cmd,
    input  logic [YCR1_AWIDTH-1:0] m0_addr,
    output logic                   m0_req_ack,
    output logic [YCR1_DWIDTH-1:0] m0_rdata,
    output logic [1:0]             m0_resp,
    input  logic                   m1_req,
    input  logic                   m1_cmd,
    input  logic [1:0]             m1_width,
    input  logic [YCR1_AWIDTH-1:0] m1_addr,
    input  logic [YCR1_DWIDTH-1:0] m1_wdata,
    output logic                   m1_req_ack,
    output logic [YCR1_DWIDTH-1:0] m1_rdata,
    output logic [1:0]             m1_resp,
    output logic                   mem_req,
    output logic                   mem_cmd,
    output logic [1:0]             mem_width,
    output logic [YCR1_AWIDTH-1:0] mem_addr,
    output logic [YCR1_DWIDTH-1:0] mem_wdata,
    input  logic                   mem_req_ack,
    input  logic [YCR1_DWIDTH-1:0] mem_rdata,
    input  logic [1:0]             mem_resp
);

    typedef enum logic {
        FSM_ADDR = 1'b0,
        FSM_DATA = 1'b1
    } fsm_e;

    fsm_e       fsm_r;
    logic       owner_r;
    logic       grant;
    logic       win;
    logic       req_g;
    logic       accept;
    logic       in_data;
    logic [1:0] resp_n;

    assign resp_n  = ycr1_resp_norm(mem_resp);
    assign in_data = (fsm_r == FSM_DATA);

    // A finishing RDY_OK reopens the port in the same cycle
    assign win = ~rst & (~in_data | (resp_n == YCR1_MEM_RESP_RDY_OK));

    assign req_g   = grant ? m1_req : m0_req;
    assign mem_req = win & req_g;
    assign accept  = mem_req & mem_req_ack;

    assign m0_req_ack = accept & ~grant;
    assign m1_req_ack = accept & grant;

    assign mem_cmd   = grant ? m1_cmd : m0_cmd;
    assign mem_width = grant ? m1_width : YCR1_MEM_WIDTH_WORD;
    assign mem_addr  = grant ? m1_addr : m0_addr;
    assign mem_wdata = grant ? m1_wdata : '0;

    assign m0_resp  = (in_data & ~owner_r) ? resp_n : YCR1_MEM_RESP_NOTRDY;
    assign m1_resp  = (in_data & owner_r) ? resp_n : YCR1_MEM_RESP_NOTRDY;
    assign m0_rdata = (in_data & ~owner_r) ? mem_rdata : '0;
    assign m1_rdata = (in_data & owner_r) ? mem_rdata : '0;

    ycr1_arb2_rr #(
        .YCR1_ARB_RR(YCR1_ARB_RR)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({m1_req, m0_req}),
        .accept(accept),
        .stall (mem_req & ~mem_req_ack),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r   <= FSM_ADDR;
            owner_r <= 1'b0;
        end else if (accept) begin
            fsm_r   <= FSM_DATA;
            owner_r <= grant;
        end else if (in_data && resp_n != YCR1_MEM_RESP_NOTRDY) begin
            fsm_r <= FSM_ADDR;
        end
    end

endmodule
